multicycle_controller: RTL

- Next-generation MIPS control unit: a multi-cycle FSM replaces single-cycle decode.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the shared datapath enables and muxes per state.
- Adds a latency-tracked multiply/divide unit (MDU) interface for mult, div, mfhi and mflo, with interlock stalls.
- Sits between the instruction register and the existing datapath (PC/NPC, GRF, ALU, DM, MDU).

---
 rtl/multicycle_controller_pkg.sv | 85 ++++++++
 rtl/multicycle_controller_mdu_busy_counter.sv | 28 ++
 rtl/multicycle_controller.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, datapath
// select codes, opcode/funct values and the instruction classifier.
package multicycle_controller_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [3:0] ALUOP_ADD = 4'd0;
  localparam logic [3:0] ALUOP_SUB = 4'd1;
  localparam logic [3:0] ALUOP_ORI = 4'd2;
  localparam logic [3:0] ALUOP_LUI = 4'd3;
  localparam logic [3:0] ALUOP_EQU = 4'd4;

  localparam logic [1:0] NPC_ADD4   = 2'd0;
  localparam logic [1:0] NPC_OFFSET = 2'd1;
  localparam logic [1:0] NPC_JUMP_S = 2'd2;
  localparam logic [1:0] NPC_JUMP_L = 2'd3;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] REGSRC_ALU  = 2'd0;
  localparam logic [1:0] REGSRC_DM   = 2'd1;
  localparam logic [1:0] REGSRC_LINK = 2'd2;
  localparam logic [1:0] REGSRC_HILO = 2'd3;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_NOP  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;

  typedef enum logic [3:0] {
    I_NOP, I_ILLEGAL, I_ADD, I_SUB, I_ORI, I_LUI, I_LW, I_SW,
    I_BEQ, I_JAL, I_JR, I_MULT, I_DIV, I_MFHI, I_MFLO
  } instr_t;

  // Collapse the IR opcode/funct fields into one instruction class.
  function automatic instr_t decode_instr(input logic [5:0] opcode,
                                          input logic [5:0] funct);
    instr_t kind;
    kind = I_ILLEGAL;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          FN_NOP:  kind = I_NOP;
          FN_ADD:  kind = I_ADD;
          FN_SUB:  kind = I_SUB;
          FN_JR:   kind = I_JR;
          FN_MULT: kind = I_MULT;
          FN_DIV:  kind = I_DIV;
          FN_MFHI: kind = I_MFHI;
          FN_MFLO: kind = I_MFLO;
          default: kind = I_ILLEGAL;
        endcase
      end
      OP_ORI:  kind = I_ORI;
      OP_LUI:  kind = I_LUI;
      OP_LW:   kind = I_LW;
      OP_SW:   kind = I_SW;
      OP_BEQ:  kind = I_BEQ;
      OP_JAL:  kind = I_JAL;
      default: kind = I_ILLEGAL;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/multicycle_controller_mdu_busy_counter.sv
// Tracks how many cycles remain before the MDU result is readable.
module mdu_busy_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             busy
);

  logic [CNT_W-1:0] count;

  // Load on a start, otherwise count down and hold at zero.
  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB and
// interlocks mult/div/mfhi/mflo against the MDU busy counter.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       cmp,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic [1:0] npc_sel,
  output logic [1:0] reg_dst,
  output logic [1:0] reg_src,
  output logic [3:0] alu_ctr,
  output logic       alu_src,
  output logic       imm_src,
  output logic       mdu_start,
  output logic       mdu_op,
  output logic       hilo_sel,
  output logic       mdu_busy,
  output logic       illegal,
  output logic [2:0] state
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  state_t           cur_state;
  state_t           next_state;
  instr_t           instr;
  logic             busy;
  logic             mdu_load;
  logic [CNT_W-1:0] mdu_load_value;

  assign instr = decode_instr(opcode, funct);

  mdu_busy_counter #(.CNT_W(CNT_W)) u_mdu_busy_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (mdu_load),
    .load_value (mdu_load_value),
    .busy       (busy)
  );

  // State register; reset returns to FETCH, aborting any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) cur_state <= S_FETCH;
    else       cur_state <= next_state;
  end

  // Next-state and Moore outputs from the state and the current IR contents.
  // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    next_state     = cur_state;
    pc_write       = 1'b0;
    ir_write       = 1'b0;
    reg_write      = 1'b0;
    mem_write      = 1'b0;
    npc_sel        = NPC_ADD4;
    reg_dst        = REGDST_RT;
    reg_src        = REGSRC_ALU;
    alu_ctr        = ALUOP_ADD;
    alu_src        = 1'b0;
    imm_src        = 1'b0;
    mdu_start      = 1'b0;
    mdu_op         = 1'b0;
    hilo_sel       = 1'b0;
    illegal        = 1'b0;
    mdu_load       = 1'b0;
    mdu_load_value = '0;
    if (reset) begin
      next_state = S_FETCH;
    end else begin
      case (cur_state)
        S_FETCH: begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end
        S_DECODE: begin
          case (instr)
            I_NOP:          next_state = S_FETCH;
            I_ILLEGAL: begin
              illegal    = 1'b1;
              next_state = S_FETCH;
            end
            I_JAL:          next_state = S_WB;
            I_MFHI, I_MFLO: next_state = busy ? S_DECODE : S_WB;
            I_MULT, I_DIV:  next_state = busy ? S_DECODE : S_EXEC;
            default:        next_state = S_EXEC;
          endcase
        end
        S_EXEC: begin
          next_state = S_WB;
          case (instr)
            I_SUB: alu_ctr = ALUOP_SUB;
            I_ORI: begin
              alu_ctr = ALUOP_ORI;
              alu_src = 1'b1;
            end
            I_LUI: begin
              alu_ctr = ALUOP_LUI;
              alu_src = 1'b1;
            end
            I_LW, I_SW: begin
              alu_src    = 1'b1;
              next_state = S_MEM;
            end
            I_BEQ: begin
              alu_ctr    = ALUOP_EQU;
              npc_sel    = NPC_OFFSET;
              pc_write   = cmp;
              next_state = S_FETCH;
            end
            I_JR: begin
              imm_src    = 1'b1;
              pc_write   = 1'b1;
              npc_sel    = NPC_JUMP_L;
              next_state = S_FETCH;
            end
            I_MULT: begin
              mdu_start      = 1'b1;
              mdu_load       = 1'b1;
              mdu_load_value = MULT_LOAD;
              next_state     = S_FETCH;
            end
            I_DIV: begin
              mdu_start      = 1'b1;
              mdu_op         = 1'b1;
              mdu_load       = 1'b1;
              mdu_load_value = DIV_LOAD;
              next_state     = S_FETCH;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          if (instr == I_SW) begin
            mem_write  = 1'b1;
            next_state = S_FETCH;
          end else begin
            next_state = S_WB;
          end
        end
        S_WB: begin
          reg_write  = 1'b1;
          next_state = S_FETCH;
          case (instr)
            I_ADD, I_SUB: reg_dst = REGDST_RD;
            I_LW:         reg_src = REGSRC_DM;
            I_JAL: begin
              reg_dst  = REGDST_RA;
              reg_src  = REGSRC_LINK;
              pc_write = 1'b1;
              npc_sel  = NPC_JUMP_S;
            end
            I_MFHI, I_MFLO: begin
              reg_dst  = REGDST_RD;
              reg_src  = REGSRC_HILO;
              hilo_sel = (instr == I_MFHI);
            end
            default: ;
          endcase
        end
        default: next_state = S_FETCH;
      endcase
    end
  end

  assign state    = reset ? 3'd0 : cur_state;
  assign mdu_busy = busy & ~reset;

endmodule
